room_fade_compositor: RTL and testbench

- Sits directly downstream of the map background renderers, which register RGB one vga_clk after DrawX/DrawY.
- Scales the incoming 4-bit RGB by a global brightness level to produce the final VGA colour.
- Runs a frame-counted room-transition sequence: fade out, hold black with a map-swap pulse, fade in.
- The game FSM uses map_swap to change the selected map while the screen is black.

---
 rtl/room_fade_compositor.sv | 183 ++++++++++++++++++
 tb/tb_room_fade_compositor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/room_fade_compositor.sv
`timescale 1ns/1ps
// room_fade_compositor
//   Final colour stage behind the map background renderers. Scales the
//   renderer RGB by a global brightness level (0..16) and runs the room
//   transition: fade out, hold black (pulsing map_swap once), fade in.
//
// Ports
//   vga_clk           pixel clock, all state on its rising edge
//   reset_n           asynchronous active-low reset
//   DrawX, DrawY      current pixel position (same timing as blank)
//   blank             active-video flag, 1 = visible
//   red_in/green_in/
//   blue_in           renderer colour, one cycle behind DrawX/DrawY
//   start_transition  single-cycle request, honoured only when idle
//   red/green/blue    scaled colour, 1 cycle after *_in, 2 after DrawX/DrawY
//   map_swap          one-cycle pulse when the screen reaches full black
//   busy              high while a transition is in progress
//   fade_level        current brightness, 0..16
module room_fade_compositor #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned BLACK_FRAMES    = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic       start_transition,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       map_swap,
  output logic       busy,
  output logic [4:0] fade_level
);

  localparam int unsigned FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned BW = (BLACK_FRAMES > 1) ? $clog2(BLACK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [BW-1:0] BLACK_LAST = BW'(BLACK_FRAMES - 1);
  localparam logic [4:0]    LEVEL_MAX  = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    BLACK,
    FADE_IN
  } state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] black_cnt;
  logic          blank_d;
  logic          prev_origin;
  logic          origin;
  logic          tick;

  // (c * lvl) >> 4 on a 9-bit product; level 16 is exact passthrough.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    logic [8:0] prod;
    prod = 9'(c) * 9'(lvl);
    return 4'(prod >> 4);
  endfunction

  // One tick per frame: rising edge of "at origin", so a held origin
  // position cannot advance the sequence more than once.
  always_comb begin
    origin = (DrawX == '0) && (DrawY == '0);
    tick   = origin && !prev_origin;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_origin <= 1'b0;
    end else begin
      prev_origin <= origin;
    end
  end

  // blank is delayed one cycle to line up with the renderer colour.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      blank_d <= blank;
      if (blank_d) begin
        red   <= scale(red_in,   fade_level);
        green <= scale(green_in, fade_level);
        blue  <= scale(blue_in,  fade_level);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // Transition sequencer. Level changes land on the tick edge, so the
  // first pixel of the frame is already drawn at the new brightness.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fade_level <= LEVEL_MAX;
      frame_cnt  <= '0;
      black_cnt  <= '0;
      map_swap   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      map_swap <= 1'b0;
      case (state)
        IDLE: begin
          fade_level <= LEVEL_MAX;
          if (start_transition) begin
            state     <= FADE_OUT;
            frame_cnt <= '0;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        FADE_OUT: begin
          busy <= 1'b1;
          if (tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt  <= '0;
              fade_level <= fade_level - 5'd1;
              if (fade_level == 5'd1) begin
                state     <= BLACK;
                black_cnt <= '0;
                map_swap  <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        BLACK: begin
          busy       <= 1'b1;
          fade_level <= '0;
          if (tick) begin
            if (black_cnt == BLACK_LAST) begin
              state     <= FADE_IN;
              frame_cnt <= '0;
            end else begin
              black_cnt <= black_cnt + 1'b1;
            end
          end
        end

        FADE_IN: begin
          busy <= 1'b1;
          if (tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt  <= '0;
              fade_level <= fade_level + 5'd1;
              if (fade_level == LEVEL_MAX - 5'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          fade_level <= LEVEL_MAX;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_room_fade_compositor.sv
`timescale 1ns/1ps
module tb_room_fade_compositor;

  localparam int FPS     = 2;
  localparam int BF      = 4;
  localparam int OUT_END = 16 * FPS;
  localparam int BLK_END = OUT_END + BF;
  localparam int TOTAL   = BLK_END + 16 * FPS;
  localparam int W       = 8;
  localparam int H       = 4;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [3:0] red_in, green_in, blue_in;
  logic       start_transition;
  logic [3:0] red, green, blue;
  logic       map_swap, busy;
  logic [4:0] fade_level;

  room_fade_compositor #(
    .FRAMES_PER_STEP(FPS),
    .BLACK_FRAMES(BF)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank(blank),
    .red_in(red_in),
    .green_in(green_in),
    .blue_in(blue_in),
    .start_transition(start_transition),
    .red(red),
    .green(green),
    .blue(blue),
    .map_swap(map_swap),
    .busy(busy),
    .fade_level(fade_level)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pixel generator and frame-level model state
  int          gx, gy, hold;
  bit          m_active;
  int          m_t;
  bit          m_prev_origin, m_blank_prev;
  int          m_lvl;
  logic [11:0] sb[$];
  bit          force_en;
  logic [11:0] force_rgb;
  int          swap_count, swap_tick, busy_fall_tick;
  bit          busy_prev;

  // Brightness as a function of ticks since start, from the fade schedule.
  function automatic int level_of(input bit act, input int t);
    if (!act)          return 16;
    if (t <= OUT_END)  return 16 - t / FPS;
    if (t < BLK_END)   return 0;
    return (t - BLK_END) / FPS;
  endfunction

  function automatic logic [3:0] scl(input logic [3:0] c, input int l);
    int p;
    p = int'(c) * l;
    return 4'(p >> 4);
  endfunction

  task automatic cycle(input bit st);
    logic [11:0] rgb, exp_rgb;
    bit org, tck, swp;
    @(negedge vga_clk);
    DrawX = 10'(gx);
    DrawY = 10'(gy);
    blank = (gx < 6) && (gy < 3);
    rgb = force_en ? force_rgb : 12'($urandom);
    {red_in, green_in, blue_in} = rgb;
    start_transition = st;
    exp_rgb = m_blank_prev ? {scl(rgb[11:8], m_lvl), scl(rgb[7:4], m_lvl), scl(rgb[3:0], m_lvl)} : 12'h000;
    sb.push_back(exp_rgb);
    m_blank_prev = blank;
    org = (gx == 0) && (gy == 0);
    tck = org && !m_prev_origin;
    m_prev_origin = org;
    swp = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_t = 0;
      end
    end else if (tck) begin
      m_t++;
      if (m_t == OUT_END) swp = 1'b1;
      if (m_t == TOTAL) m_active = 1'b0;
    end
    m_lvl = level_of(m_active, m_t);
    @(posedge vga_clk);
    #1;
    check("rgb", {red, green, blue}, sb.pop_front());
    check("fade_level", fade_level, m_lvl);
    check("busy", busy, m_active);
    check("map_swap", map_swap, swp);
    if (map_swap) begin
      swap_count++;
      swap_tick = m_t;
    end
    if (busy_prev && !busy) busy_fall_tick = m_t;
    busy_prev = busy;
    if (hold > 0) hold--;
    else begin
      gx++;
      if (gx == W) begin
        gx = 0;
        gy++;
        if (gy == H) gy = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t = 0;
    m_lvl = 16;
    m_blank_prev = 1'b0;
    m_prev_origin = 1'b0;
    busy_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit ign_done, held, done;
    gx = 0; gy = 0; hold = 0;
    swap_count = 0; swap_tick = -1; busy_fall_tick = -1;
    force_en = 1'b0; force_rgb = 12'h000;
    model_reset();

    // Reset with visible full-scale colour applied
    reset_n = 1'b0;
    DrawX = 10'd3; DrawY = 10'd0; blank = 1'b1;
    red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF;
    start_transition = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_level", fade_level, 16);
    check("rst_busy", busy, 0);
    check("rst_swap", map_swap, 0);
    #1 reset_n = 1'b1;

    // Idle passthrough: F first, then A/3/F, then random
    force_en = 1'b1; force_rgb = 12'hFFF;
    for (int i = 0; i < W * H; i++) cycle(1'b0);
    force_rgb = 12'hA3F;
    for (int i = 0; i < W * H; i++) cycle(1'b0);
    force_en = 1'b0;

    // Transition 1: ignored start at tick 10, origin held at tick 20
    while (!(gx == 3 && gy == 1)) cycle(1'b0);
    cycle(1'b1);
    ign_done = 1'b0; held = 1'b0; done = 1'b0;
    for (int i = 0; i < 80 * W * H && !done; i++) begin
      bit st;
      st = (m_t == 10) && (gx == 2) && (gy == 0) && !ign_done;
      if (st) ign_done = 1'b1;
      if (gx == 0 && gy == 0 && m_t == 20 && !held && hold == 0) begin
        hold = 4;
        held = 1'b1;
      end
      force_en = (m_lvl == 15) || (m_lvl == 8);
      force_rgb = (m_lvl == 15) ? 12'hFFF : 12'hAAA;
      cycle(st);
      done = (busy_fall_tick >= 0);
    end
    force_en = 1'b0;
    check("busy_fall_tick", busy_fall_tick, TOTAL);
    check("swap_count", swap_count, 1);
    check("swap_tick", swap_tick, OUT_END);

    // Unscaled again after the sequence
    for (int i = 0; i < W * H; i++) cycle(1'b0);

    // Transition 2: start coincident with a tick, reset during fade-in
    while (!(gx == 0 && gy == 0)) cycle(1'b0);
    cycle(1'b1);
    swap_count = 0;
    done = 1'b0;
    for (int i = 0; i < 80 * W * H && !done; i++) begin
      cycle(1'b0);
      done = (m_t == 54) && (gx == 4);
    end
    check("pre_rst_level", fade_level, 9);
    check("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rgb", {red, green, blue}, 12'h000);
    check("async_level", fade_level, 16);
    check("async_busy", busy, 0);
    check("async_swap", map_swap, 0);
    repeat (2) @(posedge vga_clk);
    #2 reset_n = 1'b1;
    model_reset();
    swap_count = 0;
    for (int i = 0; i < 3 * W * H; i++) cycle(1'b0);
    check("swap_after_rst", swap_count, 0);
    check("level_after_rst", fade_level, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
